// File: rtl/lut_vector_requester.sv
// ---------------------------------------------------------------------------
// lut_vector_requester
//
// Initiator side of the vectoring LUT interface for the HCORDIC datapath.
// A request (x, y, mode) is accepted in IDLE. The LUT address is taken from
// the saturated magnitude of y. One enable strobe is issued, the block waits
// for done, and then it latches kappa/theta/delta. The results are held for
// the next CORDIC stage behind a valid/ready handshake.
//
// Optional build macro: LUT_REQ_TIMEOUT_EN
//   When this macro is defined, a watchdog aborts a WAIT that lasts
//   WAIT_MAX cycles. It pulses err and returns to IDLE.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   start                 request strobe (sampled in IDLE only)
//   x_in, y_in, mode_in   request operands; mode 01 circular, 11 hyperbolic
//   busy                  high whenever the block is not in IDLE
//   err                   one-cycle pulse: illegal mode or watchdog timeout
//   lut_mode/address/enable/operation   request side of the LUT
//   lut_done, lut_kappa/theta/delta     response side of the LUT
//   out_valid, out_ready  result handshake to the next stage
//   x_out, kappa_out, theta_out, delta_out   latched results
// ---------------------------------------------------------------------------
module lut_vector_requester #(
  parameter int DW       = 32,
  parameter int AW       = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] x_in,
  input  logic [DW-1:0] y_in,
  input  logic [1:0]    mode_in,
  output logic          busy,
  output logic          err,
  output logic [1:0]    lut_mode,
  output logic [AW-1:0] lut_address,
  output logic          lut_enable,
  output logic          lut_operation,
  input  logic          lut_done,
  input  logic [DW-1:0] lut_kappa,
  input  logic [DW-1:0] lut_theta,
  input  logic [DW-1:0] lut_delta,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] x_out,
  output logic [DW-1:0] kappa_out,
  output logic [DW-1:0] theta_out,
  output logic [DW-1:0] delta_out
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t state, state_next;

  logic signed [DW-1:0] y_p0;
  logic                 accept;
  logic                 illegal;
  logic                 timeout;

  // The most negative y has no positive twin, so its magnitude clamps to
  // max-positive. The address is the AW bits just below the sign position.
  function automatic logic [AW-1:0] sat_abs_addr(input logic signed [DW-1:0] v);
    logic [DW-1:0] mag;
    if (v == {1'b1, {(DW-1){1'b0}}})
      mag = {1'b0, {(DW-1){1'b1}}};
    else if (v < 0)
      mag = -v;
    else
      mag = v;
    return mag[DW-2 -: AW];
  endfunction

  assign y_p0    = y_in;
  // Only the legal modes (01 circular, 11 hyperbolic) have bit 0 set.
  assign accept  = (state == S_IDLE) && start &&  mode_in[0];
  assign illegal = (state == S_IDLE) && start && !mode_in[0];

`ifdef LUT_REQ_TIMEOUT_EN
  localparam int CW = ($clog2(WAIT_MAX + 1) > 4) ? $clog2(WAIT_MAX + 1) : 4;

  logic [CW-1:0] wait_cnt;

  // The counter is cleared while in REQ, so it reads 0 on the first WAIT
  // cycle. The timeout fires on the cycle whose increment would reach
  // WAIT_MAX.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      wait_cnt <= '0;
    else if (state == S_REQ)
      wait_cnt <= '0;
    else if (state == S_WAIT && !lut_done)
      wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (state == S_WAIT) && !lut_done && (wait_cnt == CW'(WAIT_MAX - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = S_REQ;
      S_REQ:  state_next = S_WAIT;
      S_WAIT: begin
        if (lut_done)
          state_next = S_HOLD;
        else if (timeout)
          state_next = S_IDLE;
      end
      S_HOLD: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy          = (state != S_IDLE);
    lut_enable    = (state == S_REQ);
    out_valid     = (state == S_HOLD);
    lut_operation = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      err <= 1'b0;
    else
      err <= illegal || timeout;
  end

  // Request capture (IDLE) and response capture (WAIT)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_out       <= '0;
      lut_mode    <= '0;
      lut_address <= '0;
      kappa_out   <= '0;
      theta_out   <= '0;
      delta_out   <= '0;
    end else begin
      if (accept) begin
        x_out       <= x_in;
        lut_mode    <= mode_in;
        lut_address <= sat_abs_addr(y_p0);
      end
      if (state == S_WAIT && lut_done) begin
        kappa_out <= lut_kappa;
        theta_out <= lut_theta;
        delta_out <= lut_delta;
      end
    end
  end

endmodule
